// File: rtl/demux_1to4_tdm.sv
// Registered 1-to-4 time-division demultiplexer with explicit (sel) or auto round-robin routing.
// Optional macro DEMUX_FRAME_LATCH_EN: auto-mode frames collect in shadow registers and publish atomically.
module demux_1to4_tdm #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             mode,
    input  logic [1:0]       sel,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] y0,
    output logic [WIDTH-1:0] y1,
    output logic [WIDTH-1:0] y2,
    output logic [WIDTH-1:0] y3,
    output logic [3:0]       y_valid,
    output logic [1:0]       ch_ptr,
    output logic             frame_done,
    output logic             sync_err
);

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned PTR_W  = 2;
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(NUM_CH - 1);

    logic [WIDTH-1:0]  y_q [NUM_CH];
    logic [PTR_W-1:0]  target_c;
    logic [NUM_CH-1:0] onehot_c;
    logic              resync_c;

`ifdef DEMUX_FRAME_LATCH_EN
    logic [WIDTH-1:0]  shadow [NUM_CH];
`endif

    // Route selection: frame_sync realigns auto mode to slot 0
    always_comb begin
        target_c = sel;
        if (mode) begin
            target_c = frame_sync ? '0 : ch_ptr;
        end
        onehot_c = 4'b0001 << target_c;
        resync_c = mode & din_valid & frame_sync & (ch_ptr != '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_q[0]     <= '0;
            y_q[1]     <= '0;
            y_q[2]     <= '0;
            y_q[3]     <= '0;
            y_valid    <= '0;
            ch_ptr     <= '0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
`ifdef DEMUX_FRAME_LATCH_EN
            shadow[0]  <= '0;
            shadow[1]  <= '0;
            shadow[2]  <= '0;
            shadow[3]  <= '0;
`endif
        end else begin
            y_valid    <= '0;
            frame_done <= 1'b0;
            if (!mode) begin
                // Explicit mode drops any partial auto-frame position
                ch_ptr <= '0;
                if (din_valid) begin
                    y_q[sel] <= din;
                    y_valid  <= onehot_c;
                end
            end else if (din_valid) begin
                ch_ptr     <= target_c + PTR_W'(1);
                frame_done <= (target_c == LAST_SLOT);
                if (resync_c) begin
                    sync_err <= 1'b1;
                end
`ifdef DEMUX_FRAME_LATCH_EN
                shadow[target_c] <= din;
                // Slot 3 completes the frame: publish all four channels together
                if (target_c == LAST_SLOT) begin
                    y_q[0]  <= shadow[0];
                    y_q[1]  <= shadow[1];
                    y_q[2]  <= shadow[2];
                    y_q[3]  <= din;
                    y_valid <= '1;
                end
`else
                y_q[target_c] <= din;
                y_valid       <= onehot_c;
`endif
            end
        end
    end

    assign y0 = y_q[0];
    assign y1 = y_q[1];
    assign y2 = y_q[2];
    assign y3 = y_q[3];

endmodule

// File: tb/tb_demux_1to4_tdm.sv
// Bench for demux_1to4_tdm: directed test-plan steps then randomized traffic against a slot-level model.
module tb_demux_1to4_tdm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       mode;
    logic [1:0] sel;
    logic       frame_sync;
    logic [7:0] y0, y1, y2, y3;
    logic [3:0] y_valid;
    logic [1:0] ch_ptr;
    logic       frame_done;
    logic       sync_err;

    int tests = 0;
    int fails = 0;

    // Reference state: channel words, shadow words, slot pointer, pulses, sticky error
    int m_y  [4];
    int m_sh [4];
    int m_ptr, m_vld, m_fd, m_err;

    demux_1to4_tdm #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .mode       (mode),
        .sel        (sel),
        .frame_sync (frame_sync),
        .y0         (y0),
        .y1         (y1),
        .y2         (y2),
        .y3         (y3),
        .y_valid    (y_valid),
        .ch_ptr     (ch_ptr),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic r, input logic dv, input logic m,
                         input logic [1:0] s, input logic fs, input logic [7:0] d);
        int t;
        if (!r) begin
            for (int i = 0; i < 4; i++) begin
                m_y[i]  = 0;
                m_sh[i] = 0;
            end
            m_ptr = 0; m_vld = 0; m_fd = 0; m_err = 0;
        end else begin
            m_vld = 0;
            m_fd  = 0;
            if (!m) begin
                m_ptr = 0;
                if (dv) begin
                    m_y[s] = int'(d);
                    m_vld  = 1 << s;
                end
            end else if (dv) begin
                t = fs ? 0 : m_ptr;
                if (fs && m_ptr != 0) m_err = 1;
                m_ptr = (t + 1) % 4;
                m_fd  = (t == 3) ? 1 : 0;
`ifdef DEMUX_FRAME_LATCH_EN
                m_sh[t] = int'(d);
                if (t == 3) begin
                    for (int i = 0; i < 3; i++) m_y[i] = m_sh[i];
                    m_y[3] = int'(d);
                    m_vld  = 15;
                end
`else
                m_y[t] = int'(d);
                m_vld  = 1 << t;
`endif
            end
        end
    endtask

    task automatic check_all();
        chk("y0",         32'(y0),         32'(m_y[0]));
        chk("y1",         32'(y1),         32'(m_y[1]));
        chk("y2",         32'(y2),         32'(m_y[2]));
        chk("y3",         32'(y3),         32'(m_y[3]));
        chk("y_valid",    32'(y_valid),    32'(m_vld));
        chk("ch_ptr",     32'(ch_ptr),     32'(m_ptr));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
        chk("sync_err",   32'(sync_err),   32'(m_err));
        chk("y_valid_onehot", 32'($countones(y_valid) <= 1 || y_valid == 4'b1111), 32'(1));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then sample after the edge
    task automatic step(input logic r, input logic dv, input logic m,
                        input logic [1:0] s, input logic fs, input logic [7:0] d);
        rst_n      = r;
        din_valid  = dv;
        mode       = m;
        sel        = s;
        frame_sync = fs;
        din        = d;
        @(posedge clk);
        model(r, dv, m, s, fs, d);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0; din = '0; din_valid = 1'b0; mode = 1'b0; sel = '0; frame_sync = 1'b0;
        step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 2'd0, 1'b1, 8'hEE);
        chk("reset_y0", 32'(y0), 32'h0);
        chk("reset_ptr", 32'(ch_ptr), 32'h0);

        // Explicit routing
        step(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 8'hA5);
        chk("exp_y2", 32'(y2), 32'hA5);
        chk("exp_v2", 32'(y_valid), 32'b0100);
        step(1'b1, 1'b1, 1'b0, 2'd0, 1'b1, 8'h3C);
        chk("exp_y0", 32'(y0), 32'h3C);
        chk("exp_v0", 32'(y_valid), 32'b0001);
        step(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 8'hFF);
        chk("exp_y3", 32'(y3), 32'hFF);
        chk("exp_v3", 32'(y_valid), 32'b1000);
        chk("exp_y1", 32'(y1), 32'h0);
        chk("exp_ptr", 32'(ch_ptr), 32'h0);
        chk("exp_noerr", 32'(sync_err), 32'h0);

        // Auto frame
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 8'h11);
        chk("auto_ptr1", 32'(ch_ptr), 32'd1);
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 8'h22);
        chk("auto_ptr2", 32'(ch_ptr), 32'd2);
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 8'h33);
        chk("auto_ptr3", 32'(ch_ptr), 32'd3);
        chk("auto_fd_early", 32'(frame_done), 32'd0);
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 8'h44);
        chk("auto_ptr0", 32'(ch_ptr), 32'd0);
        chk("auto_fd", 32'(frame_done), 32'd1);
        chk("auto_y", {y3, y2, y1, y0}, 32'h44332211);
        step(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 8'h00);
        chk("auto_fd_once", 32'(frame_done), 32'd0);

        // Gaps
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 8'h10);
        step(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 8'h99);
        chk("gap_ptr", 32'(ch_ptr), 32'd1);
        step(1'b1, 1'b0, 1'b1, 2'd0, 1'b1, 8'h98);
        chk("gap_ptr2", 32'(ch_ptr), 32'd1);
        chk("gap_vld", 32'(y_valid), 32'd0);
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 8'h20);
        chk("gap_ptr3", 32'(ch_ptr), 32'd2);
        chk("gap_noerr", 32'(sync_err), 32'd0);

        // Early sync
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 8'h01);
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 8'h02);
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 8'h03);
        chk("es_ptr", 32'(ch_ptr), 32'd1);
        chk("es_err", 32'(sync_err), 32'd1);
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 8'h04);
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 8'h05);
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 8'h06);
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 8'h07);
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 8'h08);
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 8'h09);
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 8'h0A);
        chk("es_sticky", 32'(sync_err), 32'd1);

        // Mode switch and reset
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 8'h61);
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 8'h62);
        chk("ms_ptr2", 32'(ch_ptr), 32'd2);
        step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 8'h00);
        chk("ms_ptr0", 32'(ch_ptr), 32'd0);
        step(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 8'h55);
        chk("ms_ptr1", 32'(ch_ptr), 32'd1);
`ifndef DEMUX_FRAME_LATCH_EN
        chk("ms_y0", 32'(y0), 32'h55);
`endif
        step(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 8'h77);
        chk("rst_y", {y3, y2, y1, y0}, 32'h0);
        chk("rst_err", 32'(sync_err), 32'd0);
        chk("rst_misc", {26'd0, y_valid, ch_ptr}, 32'd0);

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 59) != 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 4) != 0),
                 2'($urandom),
                 ($urandom_range(0, 5) == 0),
                 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
